rv_fetch_decode: RTL and testbench
==================================

# rv_fetch_decode

Upstream control stage for the register-file/ALU datapath. Fetches 32-bit instructions from an instruction memory over a req/ack handshake and decodes RV32I R-type instructions into the datapath's control inputs: register numbers, 4-bit ALU control and regwrite. It sequences one instruction at a time through a multi-cycle FSM and reports illegal instructions, memory timeouts and a retired-instruction count.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- MEM_TIMEOUT, 255, maximum FETCH cycles without imem_ack before entering FAULT (1..255)

- clock  in  1  single system clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- run  in  1  level; allows new fetches
- imem_req  out  1  fetch request, held until ack
- imem_addr  out  32  fetch address (= pc), stable while imem_req is high
- imem_ack  in  1  read data valid this cycle
- imem_rdata  in  32  instruction word, sampled when imem_req && imem_ack
- read_reg_num1  out  5  rs1 = instr[19:15]
- read_reg_num2  out  5  rs2 = instr[24:20]
- write_reg  out  5  rd = instr[11:7]
- alu_control  out  4  decoded ALU operation
- regwrite  out  1  register-file write enable, one-cycle pulse
- illegal_instr  out  1  one-cycle pulse for an undecodable word
- fault  out  1  sticky memory-timeout flag
- pc  out  32  address of the current instruction
- retired  out  32  count of legal instructions completed

## Operation
- States: IDLE, FETCH, DECODE, EXEC, FAULT.
- IDLE: when run=1, go to FETCH; otherwise stay.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_ack: latch imem_rdata into the instruction register and go to DECODE.
  - Timeout counter increments each FETCH cycle without ack. If it reaches MEM_TIMEOUT, go to FAULT.
- DECODE: register fields and alu_control are driven from the instruction register; regwrite=0 (operand/ALU settle cycle).
- EXEC:
  - Fields unchanged.
  - regwrite=1 only if the instruction is legal and rd≠0.
  - illegal_instr=1 if illegal.
  - retired increments if legal, including rd=0.
  - pc ← pc+4 (mod 2^32, wraps 0xFFFF_FFFC→0x0000_0000), also for illegal words.
  - Next state: FETCH if run=1, else IDLE.
- FAULT: all pulses 0, imem_req=0, fault=1; exit only by reset.
- Legal only when opcode = 7'b0110011. Decode (funct7/funct3 → alu_control):
  - 0000000/000 ADD → 0010
  - 0100000/000 SUB → 0110
  - 0000000/111 AND → 0000
  - 0000000/110 OR → 0001
  - 0000000/100 XOR → 0011
  - 0000000/001 SLL → 0100
  - 0000000/101 SRL → 0101
  - 0100000/101 SRA → 0111
  - 0000000/010 SLT → 1000
  - 0000000/011 SLTU → 1001
  - Any other combination is illegal and drives alu_control=1111.
- run deasserting mid-instruction does not abort it; the instruction completes through EXEC.
- imem_ack while imem_req=0 is ignored.

## Timing
- Reset values: state=IDLE, pc=RESET_PC, retired=0, fault=0, instruction register=0, all other outputs 0 (alu_control=0000).
- Reset mid-operation: all of the above take effect at that edge; imem_req is low in the next cycle and no regwrite is issued.
- Minimum latency is 3 cycles per instruction, with ack in the first FETCH cycle (FETCH, DECODE, EXEC). Each wait cycle adds one.
- imem_addr and imem_req must not change while a request is outstanding.
- Register fields are stable from the first DECODE cycle through the end of EXEC.
- The register-file write occurs at the clock edge ending EXEC.
- Timeout: the FAULT transition happens at the edge ending the MEM_TIMEOUT-th consecutive un-acked FETCH cycle. An ack in that same cycle wins.
- retired wraps 0xFFFF_FFFF→0.

## Test plan
- Reset then run=1, imem_ack tied 1, word 0x003100B3 (add x1,x2,x3) at 0x0:
  - rs1=2, rs2=3, rd=1, alu_control=0010.
  - regwrite pulse in cycle 3.
  - pc=0x4 and retired=1 afterwards.
- Sequence SUB (0x40208233), SRA (0x4020D233), SLTU (0x0020B233) with 2-cycle ack delay:
  - alu_control 0110, 0111, 1001.
  - 5 cycles per instruction; imem_addr stable while waiting.
- Word 0x00000013 (addi), then add with rd=x0 (0x00310033):
  - First: illegal_instr pulse, no regwrite, pc advances.
  - Second: no regwrite, retired increments by 1 total.
- MEM_TIMEOUT=4, ack never asserted: fault=1 after 4 FETCH cycles, imem_req=0, state held until reset.
- RESET_PC=0xFFFF_FFFC with a legal word: pc wraps to 0x0000_0000 after EXEC; run dropped during DECODE completes the instruction and then goes to IDLE.
- Reset asserted during FETCH wait and during EXEC: next cycle pc=RESET_PC, imem_req=0, regwrite=0, retired=0.

Source files
------------

// File: rtl/rv_fetch_decode.sv
`default_nettype none
// ============================================================================
// Module   : rv_fetch_decode
// Purpose  : Instruction fetch over a req/ack memory port and RV32I R-type
//            decode into register numbers, ALU control and regwrite.
//            One instruction is in flight at a time:
//            IDLE -> FETCH -> DECODE -> EXEC.
//            A fetch that is never acknowledged parks the block in FAULT.
// Revision : 1.0 - initial release
// ============================================================================
module rv_fetch_decode #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [4:0]  read_reg_num1,
    output logic [4:0]  read_reg_num2,
    output logic [4:0]  write_reg,
    output logic [3:0]  alu_control,
    output logic        regwrite,
    output logic        illegal_instr,
    output logic        fault,
    output logic [31:0] pc,
    output logic [31:0] retired
);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_FETCH  = 3'd1;
    localparam logic [2:0] c_ST_DECODE = 3'd2;
    localparam logic [2:0] c_ST_EXEC   = 3'd3;
    localparam logic [2:0] c_ST_FAULT  = 3'd4;

    localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
    localparam logic [3:0] c_ALU_BAD   = 4'b1111;
    // Count value at which the current un-acked cycle is the last one allowed.
    localparam logic [7:0] c_TMO_LAST  = 8'(MEM_TIMEOUT - 1);

    logic [2:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_retired;
    logic [7:0]  r_tmo;
    logic [4:0]  r_rs1;
    logic [4:0]  r_rs2;
    logic [4:0]  r_rd;
    logic [3:0]  r_alu;
    logic        r_legal;
    logic        r_regwrite;
    logic        r_illegal;
    logic        r_fault;

    logic        w_dec_legal;
    logic [3:0]  w_dec_alu;

    // Decode the word on the memory bus so the result can be latched with it.
    always_comb begin
        w_dec_legal = 1'b0;
        w_dec_alu   = c_ALU_BAD;
        if (imem_rdata[6:0] == c_OP_RTYPE) begin
            w_dec_legal = 1'b1;
            case ({imem_rdata[31:25], imem_rdata[14:12]})
                {7'b0000000, 3'b000}: w_dec_alu = 4'b0010;  // ADD
                {7'b0100000, 3'b000}: w_dec_alu = 4'b0110;  // SUB
                {7'b0000000, 3'b111}: w_dec_alu = 4'b0000;  // AND
                {7'b0000000, 3'b110}: w_dec_alu = 4'b0001;  // OR
                {7'b0000000, 3'b100}: w_dec_alu = 4'b0011;  // XOR
                {7'b0000000, 3'b001}: w_dec_alu = 4'b0100;  // SLL
                {7'b0000000, 3'b101}: w_dec_alu = 4'b0101;  // SRL
                {7'b0100000, 3'b101}: w_dec_alu = 4'b0111;  // SRA
                {7'b0000000, 3'b010}: w_dec_alu = 4'b1000;  // SLT
                {7'b0000000, 3'b011}: w_dec_alu = 4'b1001;  // SLTU
                default: begin
                    w_dec_legal = 1'b0;
                    w_dec_alu   = c_ALU_BAD;
                end
            endcase
        end
    end

    // Sequencer: fetch handshake, timeout, field latching, pulses and counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= c_ST_IDLE;
            r_pc       <= RESET_PC;
            r_retired  <= 32'd0;
            r_tmo      <= 8'd0;
            r_rs1      <= 5'd0;
            r_rs2      <= 5'd0;
            r_rd       <= 5'd0;
            r_alu      <= 4'd0;
            r_legal    <= 1'b0;
            r_regwrite <= 1'b0;
            r_illegal  <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            // Pulses default low; only the DECODE->EXEC transition raises them.
            r_regwrite <= 1'b0;
            r_illegal  <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (run) begin
                        r_state <= c_ST_FETCH;
                        r_tmo   <= 8'd0;
                    end
                end
                c_ST_FETCH: begin
                    // An ack in the final allowed cycle takes priority over timeout.
                    if (imem_ack) begin
                        r_rs1   <= imem_rdata[19:15];
                        r_rs2   <= imem_rdata[24:20];
                        r_rd    <= imem_rdata[11:7];
                        r_alu   <= w_dec_alu;
                        r_legal <= w_dec_legal;
                        r_state <= c_ST_DECODE;
                    end else if (r_tmo == c_TMO_LAST) begin
                        r_state <= c_ST_FAULT;
                        r_fault <= 1'b1;
                    end else begin
                        r_tmo <= r_tmo + 8'd1;
                    end
                end
                c_ST_DECODE: begin
                    // Operand/ALU settle cycle; arm the EXEC-cycle pulses.
                    r_state    <= c_ST_EXEC;
                    r_regwrite <= r_legal && (r_rd != 5'd0);
                    r_illegal  <= ~r_legal;
                end
                c_ST_EXEC: begin
                    r_pc <= r_pc + 32'd4;
                    if (r_legal) begin
                        r_retired <= r_retired + 32'd1;
                    end
                    r_tmo   <= 8'd0;
                    r_state <= run ? c_ST_FETCH : c_ST_IDLE;
                end
                c_ST_FAULT: begin
                    r_state <= c_ST_FAULT;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign imem_req      = (r_state == c_ST_FETCH);
    assign imem_addr     = r_pc;
    assign read_reg_num1 = r_rs1;
    assign read_reg_num2 = r_rs2;
    assign write_reg     = r_rd;
    assign alu_control   = r_alu;
    assign regwrite      = r_regwrite;
    assign illegal_instr = r_illegal;
    assign fault         = r_fault;
    assign pc            = r_pc;
    assign retired       = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_rv_fetch_decode.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv_fetch_decode
// Purpose  : Self-checking bench for rv_fetch_decode. A memory responder
//            issues words (directed and random) with chosen ack delays and
//            queues the expected execution result from an instruction-level
//            model; a monitor pops and compares when the pc advances.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv_fetch_decode;

    localparam logic [31:0] RESET_PC    = 32'hFFFF_FFF4;
    localparam int          MEM_TIMEOUT = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        run   = 1'b0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [4:0]  read_reg_num1, read_reg_num2, write_reg;
    logic [3:0]  alu_control;
    logic        regwrite, illegal_instr, fault;
    logic [31:0] pc, retired;

    rv_fetch_decode #(.RESET_PC(RESET_PC), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clock(clock), .reset(reset), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .read_reg_num1(read_reg_num1), .read_reg_num2(read_reg_num2),
        .write_reg(write_reg), .alu_control(alu_control),
        .regwrite(regwrite), .illegal_instr(illegal_instr), .fault(fault),
        .pc(pc), .retired(retired)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Legal R-type operations: funct7, funct3, ALU code.
    logic [6:0] t_f7  [10] = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h20, 7'h00, 7'h00};
    logic [2:0] t_f3  [10] = '{3'd0, 3'd0, 3'd7, 3'd6, 3'd4, 3'd1, 3'd5, 3'd5, 3'd2, 3'd3};
    logic [3:0] t_alu [10] = '{4'd2, 4'd6, 4'd0, 4'd1, 4'd3, 4'd4, 4'd5, 4'd7, 4'd8, 4'd9};

    typedef struct {
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  alu;
        logic        rw, ill;
        logic [31:0] pc_after, ret_after;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [31:0] word;
        int          wt;
    } dir_t;

    typedef struct {
        logic [31:0] pc, ret;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  alu;
        logic        rw, ill, rst, req, flt;
    } snap_t;

    exp_t exp_q[$];
    dir_t dir_q[$];
    bit   no_ack = 1'b0;
    logic [31:0] m_pc, m_ret;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, required 0x%08h at t=%0t", name, act, req, $time);
        end
    endtask

    function automatic void ref_decode(input logic [31:0] w, output logic legal, output logic [3:0] alu);
        legal = 1'b0;
        alu   = 4'hF;
        if (w[6:0] == 7'b0110011) begin
            for (int i = 0; i < 10; i++) begin
                if (w[31:25] == t_f7[i] && w[14:12] == t_f3[i]) begin
                    legal = 1'b1;
                    alu   = t_alu[i];
                end
            end
        end
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        int k, i;
        k = $urandom_range(0, 9);
        w = $urandom;
        if (k < 6) begin
            i = $urandom_range(0, 9);
            w[31:25] = t_f7[i];
            w[14:12] = t_f3[i];
            w[6:0]   = 7'b0110011;
            if ($urandom_range(0, 4) == 0) w[11:7] = 5'd0;
        end else if (k < 8) begin
            w[6:0] = 7'b0110011;
        end
        return w;
    endfunction

    // Memory responder: acks requests after a delay and queues the model result.
    initial begin : responder
        bit          in_req;
        int          wait_left;
        logic [31:0] req_addr, w;
        logic        lg;
        logic [3:0]  al;
        exp_t        e;
        in_req = 1'b0;
        wait_left = 0;
        req_addr = 32'd0;
        m_pc  = RESET_PC;
        m_ret = 32'd0;
        forever begin
            @(posedge clock);
            #2;
            if (reset) begin
                in_req   = 1'b0;
                imem_ack = 1'b0;
                m_pc     = RESET_PC;
                m_ret    = 32'd0;
            end else if (imem_req) begin
                if (!in_req) begin
                    in_req   = 1'b1;
                    req_addr = imem_addr;
                    chk("fetch_addr", imem_addr, m_pc);
                    wait_left = (dir_q.size() != 0) ? dir_q[0].wt : int'($urandom_range(0, MEM_TIMEOUT - 1));
                end else begin
                    chk("addr_stable", imem_addr, req_addr);
                end
                if (no_ack || wait_left > 0) begin
                    imem_ack   = 1'b0;
                    imem_rdata = $urandom;
                    if (wait_left > 0) wait_left--;
                end else begin
                    if (dir_q.size() != 0) w = dir_q.pop_front().word;
                    else w = rand_word();
                    ref_decode(w, lg, al);
                    e.rs1 = w[19:15];
                    e.rs2 = w[24:20];
                    e.rd  = w[11:7];
                    e.alu = al;
                    e.rw  = lg && (w[11:7] != 5'd0);
                    e.ill = ~lg;
                    m_pc  = m_pc + 32'd4;
                    if (lg) m_ret = m_ret + 32'd1;
                    e.pc_after  = m_pc;
                    e.ret_after = m_ret;
                    e.cyc       = cyc + 3;
                    exp_q.push_back(e);
                    imem_ack   = 1'b1;
                    imem_rdata = w;
                    in_req     = 1'b0;
                end
            end else begin
                // Spurious acks while no request is outstanding must be ignored.
                in_req     = 1'b0;
                imem_ack   = ($urandom_range(0, 3) == 0);
                imem_rdata = $urandom;
            end
        end
    end

    // Monitor: a pc change marks the end of EXEC; check that instruction.
    initial begin : monitor
        snap_t s, p1, p2;
        exp_t  e;
        int    n;
        n = 0;
        forever begin
            @(negedge clock);
            s.pc = pc; s.ret = retired; s.rs1 = read_reg_num1; s.rs2 = read_reg_num2;
            s.rd = write_reg; s.alu = alu_control; s.rw = regwrite; s.ill = illegal_instr;
            s.rst = reset; s.req = imem_req; s.flt = fault;
            if (n >= 1 && p1.rst) begin
                chk("rst_pc", s.pc, RESET_PC);
                chk("rst_req", 32'(s.req), 32'd0);
                chk("rst_regwrite", 32'(s.rw), 32'd0);
                chk("rst_illegal", 32'(s.ill), 32'd0);
                chk("rst_retired", s.ret, 32'd0);
                chk("rst_fault", 32'(s.flt), 32'd0);
                chk("rst_alu", 32'(s.alu), 32'd0);
                chk("rst_fields", {17'd0, s.rs1, s.rs2, s.rd}, 32'd0);
            end else if (n >= 2 && s.pc != p1.pc) begin
                if (exp_q.size() == 0) begin
                    chk("pending_expected", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("exec_rs1", 32'(p1.rs1), 32'(e.rs1));
                    chk("exec_rs2", 32'(p1.rs2), 32'(e.rs2));
                    chk("exec_rd", 32'(p1.rd), 32'(e.rd));
                    chk("exec_alu", 32'(p1.alu), 32'(e.alu));
                    chk("decode_fields", {13'd0, p2.alu, p2.rs1, p2.rs2, p2.rd},
                        {13'd0, e.alu, e.rs1, e.rs2, e.rd});
                    chk("regwrite", 32'(p1.rw), 32'(e.rw));
                    chk("illegal_instr", 32'(p1.ill), 32'(e.ill));
                    chk("pc_next", s.pc, e.pc_after);
                    chk("retired", s.ret, e.ret_after);
                    chk("latency_cycle", 32'(cyc), 32'(e.cyc));
                end
            end else if (n >= 1 && (p1.rw || p1.ill)) begin
                chk("stray_pulse", {30'd0, p1.rw, p1.ill}, 32'd0);
            end
            p2 = p1;
            p1 = s;
            n++;
        end
    end

    // Stimulus sequencing: directed programs, random run, resets, timeout.
    initial begin : stim
        int nf;
        logic [31:0] hold_pc;
        reset = 1'b1;
        run   = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // add, then SUB/SRA/SLTU with two wait cycles, then addi and add x0.
        dir_q.push_back('{32'h003100B3, 0});
        dir_q.push_back('{32'h40208233, 2});
        dir_q.push_back('{32'h4020D233, 2});
        dir_q.push_back('{32'h0020B233, 2});
        dir_q.push_back('{32'h00000013, 0});
        dir_q.push_back('{32'h00310033, 0});
        run = 1'b1;
        for (int i = 0; i < 200 && dir_q.size() != 0; i++) @(posedge clock);
        chk("directed_issued", 32'(dir_q.size()), 32'd0);

        // Drop run during DECODE: instruction completes, then no new fetch.
        for (int i = 0; i < 50; i++) begin
            @(posedge clock); #3;
            if (imem_req && imem_ack) break;
        end
        @(posedge clock); #1 run = 1'b0;
        repeat (3) @(posedge clock);
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #3;
            chk("idle_no_req", 32'(imem_req), 32'd0);
        end

        // Random run level with random words and delays.
        for (int i = 0; i < 700; i++) begin
            @(posedge clock); #1 run = ($urandom_range(0, 15) != 0);
        end
        run = 1'b1;

        // Reset while a fetch is waiting.
        for (int i = 0; i < 50; i++) begin
            @(posedge clock); #3;
            if (imem_req && !imem_ack) break;
        end
        @(posedge clock); #1 reset = 1'b1; exp_q.delete();
        @(posedge clock); #1 reset = 1'b0;

        // Reset during EXEC.
        for (int i = 0; i < 50; i++) begin
            @(posedge clock); #3;
            if (imem_req && imem_ack) break;
        end
        @(posedge clock);
        @(posedge clock); #1 reset = 1'b1; exp_q.delete();
        @(posedge clock); #1 reset = 1'b0;
        repeat (40) @(posedge clock);

        // Memory timeout: never ack.
        #1 run = 1'b0;
        repeat (10) @(posedge clock);
        #1 no_ack = 1'b1;
        run = 1'b1;
        nf = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clock); #3;
            if (fault) break;
            if (imem_req) nf++;
        end
        chk("timeout_fetch_cycles", 32'(nf), 32'(MEM_TIMEOUT));
        chk("fault_set", 32'(fault), 32'd1);
        hold_pc = pc;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #3;
            chk("fault_sticky", {30'd0, fault, imem_req}, 32'd2);
            chk("fault_pc_hold", pc, hold_pc);
        end
        @(posedge clock); #1 reset = 1'b1; no_ack = 1'b0; exp_q.delete();
        @(posedge clock); #1 reset = 1'b0;

        // Short random tail, then drain.
        repeat (100) @(posedge clock);
        #1 run = 1'b0;
        repeat (12) @(posedge clock);
        chk("drain_queue", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Guard against a hung run.
    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
